rom_decrypt_sequencer: RTL
==========================

# rom_decrypt_sequencer

Sequential reader that sits directly downstream of the 32-bit data ROM and walks its contents. It fetches the three-word header (operation code, key, stop character), then streams the encrypted characters and decrypts each one. Decrypted bytes leave on a valid/ready handshake towards the processor's data path or RAM writer. The stream ends at the stop character, on a malformed header, or when a length limit is hit.

## Interface
- `BASE_ADDR`, default 11'h000: byte address of the header's first word; must be word aligned.
- `MAX_CHARS`, default 64: maximum number of characters fetched before `error` is raised. Range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request, sampled only in IDLE.
- `rom_addr`  out  11  registered byte address to the ROM. Always word aligned.
- `rom_data`  in  32  combinational ROM output for the current `rom_addr`.
- `out_valid`  out  1  decrypted character available.
- `out_ready`  in  1  consumer accepts the character when `out_valid & out_ready`.
- `out_char`  out  8  decrypted character.
- `out_index`  out  8  zero-based index of `out_char` in the message.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: stop character found.
- `error`  out  1  one-cycle pulse: bad op code or `MAX_CHARS` exceeded.
- `chksum`  out  8  running XOR of accepted characters; see Configuration.

## Operation
- **States:** IDLE, F_OP, F_KEY, F_STOP, F_CHAR, EMIT, DONE, ERR.
- **IDLE:** `rom_addr`=`BASE_ADDR`. On `start`, go to F_OP.
- **F_OP:** capture `rom_data[1:0]` as op. Bits [31:2] are ignored. `rom_addr`+=4.
- **F_KEY:** capture `rom_data[7:0]` as key. `rom_addr`+=4.
- **F_STOP:** capture `rom_data[7:0]` as stop. `rom_addr`+=4.
  - If op==0, go to ERR.
  - Otherwise clear the character count and go to F_CHAR.
- **F_CHAR:** compute `c` from `e=rom_data[7:0]`. All arithmetic is 8-bit, modulo 256.
  - op 1 (XOR): `c = e ^ key`
  - op 2 (NOT): `c = ~e`
  - op 3 (add): `c = e - key`
  - If `c == stop`, go to DONE. The stop character is never emitted.
  - Else if count == `MAX_CHARS`, go to ERR.
  - Else register `out_char=c` and `out_index=count`, then go to EMIT.
- **EMIT:** hold `out_valid`=1 with stable `out_char` and `out_index` until `out_ready`.
  - On acceptance: count+=1, `rom_addr`+=4, go to F_CHAR.
- **Address overflow:** if an increment would pass 11'h7FC, go to ERR instead of wrapping.
- **DONE / ERR:** pulse `done` / `error` for one cycle, then go to IDLE.
- **`start` outside IDLE** is ignored.

## Timing
- **Reset values:** state=IDLE, `rom_addr`=`BASE_ADDR`, `out_valid`=0, `out_char`=0, `out_index`=0, `busy`=0, `done`=0, `error`=0, `chksum`=0.
- **Reset mid-operation:** returns to IDLE on the next edge. No `done` or `error` pulse. Any pending `out_valid` drops.
- **Start latency:** with `start` sampled at edge N, `busy`=1 after N. The header is captured at N+1, N+2 and N+3. The first `out_valid` is asserted after N+4.
- **Throughput:** 2 cycles per character with `out_ready` held high.
- **Completion:** `done`/`error` are asserted the cycle after the terminating F_CHAR/F_STOP. `busy` falls the cycle after that.
- **Back-to-back start:** a new `start` is accepted in the first IDLE cycle after the pulse.
- **`chksum`** updates on the accepting edge. It is cleared on `start` acceptance.

## Configuration
- **`ROM_DECRYPT_CHKSUM_EN` defined:** `chksum` accumulates as the XOR of every accepted `out_char` in the current message and holds its value after `done`/`error`.
- **Not defined:** the accumulator is not built and `chksum` is tied to 8'h00.

## Test plan
- **NOT message:** ROM = {2, 3, 0x26, 0xB7, 0xB0, 0xB3, 0xBE, 0xD9} with `out_ready`=1.
  - Required: chars 0x48, 0x4F, 0x4C, 0x41 at indices 0..3, then `done`.
  - First `out_valid` 5 cycles after `start`.
  - `chksum`=0x48^0x4F^0x4C^0x41 when enabled.
- **XOR and add:** op=1, key=0x03, char 0x4B decrypts to 0x48. op=3, key=0x03, char 0x4B decrypts to 0x48. Add case 0x01 with key 0x03 wraps to 0xFE.
- **Backpressure:** `out_ready` low for 7 cycles on char 1.
  - `out_char`/`out_index` stay stable.
  - `rom_addr` does not advance.
  - No character is lost or duplicated.
- **Bad op:** op word 0 → `error` pulse after F_STOP, no `out_valid` ever asserted.
- **Length limit:** `MAX_CHARS`=2, no stop character present → exactly 2 characters emitted, then `error`.
- **Reset:** `rst_n` low during EMIT → all outputs at reset values next cycle. A subsequent `start` replays the message from index 0.

Source files
------------

// File: rtl/rom_decrypt_sequencer.sv
// ============================================================================
// rom_decrypt_sequencer: walks a ROM header (op, key, stop) then streams and
// decrypts characters over valid/ready. Optional macro ROM_DECRYPT_CHKSUM_EN
// builds the running XOR checksum of accepted characters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_decrypt_sequencer #(
  parameter logic [10:0] BASE_ADDR = 11'h000,
  parameter int unsigned MAX_CHARS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [10:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic [7:0]  out_index,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  chksum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_OP   = 3'd1,
    S_F_KEY  = 3'd2,
    S_F_STOP = 3'd3,
    S_F_CHAR = 3'd4,
    S_EMIT   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [10:0] C_LAST_ADDR = 11'h7FC;
  localparam logic [7:0]  C_MAX_CNT   = 8'(MAX_CHARS);

  state_t      state_q, state_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  stop_q, stop_d;
  logic [7:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_char_q, out_char_d;
  logic [7:0]  out_index_q, out_index_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  w_dec;
  logic [7:0]  w_enc;
  logic        w_last;
  logic        unused_rom_bits;

  assign w_enc  = rom_data[7:0];
  assign w_last = (rom_addr_q == C_LAST_ADDR);
  assign unused_rom_bits = ^rom_data[31:8];

  always_comb begin
    case (op_q)
      2'd1:    w_dec = w_enc ^ key_q;
      2'd2:    w_dec = ~w_enc;
      default: w_dec = w_enc - key_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    op_d        = op_q;
    key_d       = key_q;
    stop_d      = stop_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        rom_addr_d = BASE_ADDR;
        if (start) state_d = S_F_OP;
      end
      S_F_OP, S_F_KEY, S_F_STOP: begin
        if (state_q == S_F_OP)  op_d   = rom_data[1:0];
        if (state_q == S_F_KEY) key_d  = w_enc;
        if (state_q == S_F_STOP) begin
          stop_d  = w_enc;
          count_d = 8'd0;
        end
        // An op of zero is only judged once the whole header has been read.
        if (w_last || (state_q == S_F_STOP && op_q == 2'd0)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          rom_addr_d = rom_addr_q + 11'd4;
          state_d    = (state_q == S_F_OP)  ? S_F_KEY :
                       (state_q == S_F_KEY) ? S_F_STOP : S_F_CHAR;
        end
      end
      S_F_CHAR: begin
        if (w_dec == stop_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (count_q == C_MAX_CNT) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          out_char_d  = w_dec;
          out_index_d = count_q;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_q + 8'd1;
          if (w_last) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 11'd4;
            state_d    = S_F_CHAR;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        rom_addr_d = BASE_ADDR;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= BASE_ADDR;
      op_q        <= 2'd0;
      key_q       <= 8'd0;
      stop_q      <= 8'd0;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'd0;
      out_index_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      op_q        <= op_d;
      key_q       <= key_d;
      stop_q      <= stop_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef ROM_DECRYPT_CHKSUM_EN
  logic [7:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    if (state_q == S_IDLE && start)
      chksum_d = 8'd0;
    else if (state_q == S_EMIT && out_ready)
      chksum_d = chksum_q ^ out_char_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chksum_q <= 8'd0;
    else        chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`else
  assign chksum = 8'h00;
`endif

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire
